// File: rtl/color_bbox_detect.sv
// Colour-threshold pixel classifier with per-frame bounding-box accumulation.
// Publishes box, centre, hit count and found flag on each vsync rising edge,
// and emits a one-cycle-delayed binary mask stream for display overlay.
module color_bbox_detect #(
  parameter int unsigned H_PIXEL   = 640,
  parameter int unsigned V_PIXEL   = 480,
  parameter logic [4:0]  R_MIN     = 5'd20,
  parameter logic [5:0]  G_MAX     = 6'd24,
  parameter logic [4:0]  B_MAX     = 5'd12,
  parameter logic [18:0] MIN_COUNT = 19'd200
) (
  input  logic        ov5640_pclk,
  input  logic        sys_rst_n,
  input  logic        pix_en,
  input  logic [15:0] pix_data,
  input  logic        pix_vsync,
  input  logic        pix_href,
  output logic        bin_en,
  output logic [15:0] bin_data,
  output logic        bin_href,
  output logic        bin_vsync,
  output logic        obj_valid,
  output logic        obj_found,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [10:0] y_min,
  output logic [10:0] y_max,
  output logic [10:0] x_center,
  output logic [10:0] y_center,
  output logic [18:0] hit_cnt
);

  localparam logic [10:0] H_LIM = 11'(H_PIXEL);
  localparam logic [10:0] V_LIM = 11'(V_PIXEL);

  logic        vsync_d;
  logic        href_d;
  logic        armed;
  logic [10:0] x_cnt;
  logic [10:0] y_cnt;
  logic [10:0] acc_xmin;
  logic [10:0] acc_xmax;
  logic [10:0] acc_ymin;
  logic [10:0] acc_ymax;
  logic [18:0] acc_cnt;
  logic        vsync_rise;
  logic        href_fall;
  logic        match;
  logic        hit;

  // Edge strobes, colour test and in-window hit qualification
  always_comb begin
    vsync_rise = pix_vsync & ~vsync_d;
    href_fall  = ~pix_href & href_d;
    match      = (pix_data[15:11] >= R_MIN) && (pix_data[10:5] <= G_MAX) &&
                 (pix_data[4:0] <= B_MAX);
    hit        = pix_en && match && (x_cnt < H_LIM) && (y_cnt < V_LIM) && !vsync_rise;
  end

  // Registered copies of the sync inputs for edge detection
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= pix_vsync;
      href_d  <= pix_href;
    end
  end

  // Column/row counters; frame start beats line end beats pixel advance
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (vsync_rise) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (href_fall) begin
      x_cnt <= '0;
      if (y_cnt < V_LIM) y_cnt <= y_cnt + 11'd1;
    end else if (pix_en && (x_cnt < H_LIM)) begin
      x_cnt <= x_cnt + 11'd1;
    end
  end

  // Per-frame bounding box and hit-count accumulation
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (vsync_rise) begin
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (hit) begin
      if (x_cnt < acc_xmin) acc_xmin <= x_cnt;
      if (x_cnt > acc_xmax) acc_xmax <= x_cnt;
      if (y_cnt < acc_ymin) acc_ymin <= y_cnt;
      if (y_cnt > acc_ymax) acc_ymax <= y_cnt;
      if (acc_cnt != '1) acc_cnt <= acc_cnt + 19'd1;
    end
  end

  // Frame close: first vsync after reset only arms, later ones publish
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      armed     <= 1'b0;
      obj_valid <= 1'b0;
      obj_found <= 1'b0;
      x_min     <= '0;
      x_max     <= '0;
      y_min     <= '0;
      y_max     <= '0;
      x_center  <= '0;
      y_center  <= '0;
      hit_cnt   <= '0;
    end else begin
      obj_valid <= 1'b0;
      if (vsync_rise) begin
        if (!armed) begin
          armed <= 1'b1;
        end else begin
          obj_valid <= 1'b1;
          hit_cnt   <= acc_cnt;
          if (acc_cnt >= MIN_COUNT) begin
            obj_found <= 1'b1;
            x_min     <= acc_xmin;
            x_max     <= acc_xmax;
            y_min     <= acc_ymin;
            y_max     <= acc_ymax;
            x_center  <= 11'(({1'b0, acc_xmin} + {1'b0, acc_xmax}) >> 1);
            y_center  <= 11'(({1'b0, acc_ymin} + {1'b0, acc_ymax}) >> 1);
          end else begin
            obj_found <= 1'b0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            x_center  <= '0;
            y_center  <= '0;
          end
        end
      end
    end
  end

  // Binary mask stream, one cycle behind the pixel input
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_en    <= 1'b0;
      bin_data  <= '0;
      bin_href  <= 1'b0;
      bin_vsync <= 1'b0;
    end else begin
      bin_en    <= pix_en;
      bin_data  <= (pix_en && match) ? '1 : '0;
      bin_href  <= pix_href;
      bin_vsync <= pix_vsync;
    end
  end

endmodule

// File: tb/tb_color_bbox_detect.sv
// Self-checking bench for color_bbox_detect with a small frame geometry.
module tb_color_bbox_detect;

  localparam int unsigned H    = 8;
  localparam int unsigned V    = 4;
  localparam int          MINC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [15:0] pix_data = '0;
  logic        pix_vsync = 1'b0;
  logic        pix_href = 1'b0;
  logic        bin_en;
  logic [15:0] bin_data;
  logic        bin_href;
  logic        bin_vsync;
  logic        obj_valid;
  logic        obj_found;
  logic [10:0] x_min, x_max, y_min, y_max, x_center, y_center;
  logic [18:0] hit_cnt;

  color_bbox_detect #(
    .H_PIXEL  (H),
    .V_PIXEL  (V),
    .MIN_COUNT(19'd2)
  ) dut (
    .ov5640_pclk(clk),
    .sys_rst_n  (rst_n),
    .pix_en     (pix_en),
    .pix_data   (pix_data),
    .pix_vsync  (pix_vsync),
    .pix_href   (pix_href),
    .bin_en     (bin_en),
    .bin_data   (bin_data),
    .bin_href   (bin_href),
    .bin_vsync  (bin_vsync),
    .obj_valid  (obj_valid),
    .obj_found  (obj_found),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .x_center   (x_center),
    .y_center   (y_center),
    .hit_cnt    (hit_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: list of hit coordinates in the current frame
  typedef struct { int x; int y; } pt_t;
  pt_t hits[$];
  bit  m_armed = 1'b0;
  int  m_row = 0;
  int  e_found = 0, e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0;
  int  e_xc = 0, e_yc = 0, e_cnt = 0;
  logic [15:0] img [0:7][0:11];

  typedef struct { logic [15:0] d; logic [15:0] exp; } mvec_t;
  mvec_t mvec [11];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_target(logic [15:0] d);
    return (d[15:11] >= 5'd20) && (d[10:5] <= 6'd24) && (d[4:0] <= 5'd12);
  endfunction

  function automatic logic [15:0] rand_target();
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = 5'($urandom_range(20, 31));
    g = 6'($urandom_range(0, 24));
    b = 5'($urandom_range(0, 12));
    return {r, g, b};
  endfunction

  // One clock; mask outputs must reflect the inputs that were present at the edge
  task automatic step();
    logic pe, ph, pv, ok;
    logic [15:0] pd;
    pe = pix_en; pd = pix_data; ph = pix_href; pv = pix_vsync; ok = rst_n;
    @(posedge clk);
    #1;
    if (ok && rst_n) begin
      chk("bin_en", bin_en, pe);
      chk("bin_data", bin_data, (pe && is_target(pd)) ? 16'hFFFF : 16'h0000);
      chk("bin_href", bin_href, ph);
      chk("bin_vsync", bin_vsync, pv);
    end
  endtask

  task automatic check_results(string tag);
    chk({tag, "_found"}, obj_found, e_found);
    chk({tag, "_xmin"}, x_min, e_xmin);
    chk({tag, "_xmax"}, x_max, e_xmax);
    chk({tag, "_ymin"}, y_min, e_ymin);
    chk({tag, "_ymax"}, y_max, e_ymax);
    chk({tag, "_xc"}, x_center, e_xc);
    chk({tag, "_yc"}, y_center, e_yc);
    chk({tag, "_cnt"}, hit_cnt, e_cnt);
  endtask

  task automatic clear_img();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++) img[r][c] = 16'h0000;
  endtask

  task automatic drive_line(int row, int cols, bit gaps);
    pix_href = 1'b1;
    for (int c = 0; c < cols; c++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        pix_en = 1'b0; pix_data = 16'($urandom); step();
      end
      pix_en = 1'b1;
      pix_data = img[row][c];
      if (c < int'(H) && m_row < int'(V) && is_target(pix_data)) hits.push_back('{c, m_row});
      step();
    end
    pix_en = 1'b0;
    pix_data = 16'($urandom);
    pix_href = 1'b0;
    step();
    step();
    m_row++;
  endtask

  task automatic drive_frame(int rows, int cols, bit gaps);
    for (int r = 0; r < rows; r++) drive_line(r, cols, gaps);
  endtask

  // Rising vsync closes the frame; the model decides what must be published
  task automatic close_frame();
    int pulses;
    int pub;
    pulses = 0;
    pub = 0;
    pix_vsync = 1'b1;
    step();
    if (!m_armed) begin
      m_armed = 1'b1;
    end else begin
      pub = 1;
      e_cnt = hits.size();
      if (e_cnt >= MINC) begin
        e_found = 1;
        e_xmin = hits[0].x; e_xmax = hits[0].x;
        e_ymin = hits[0].y; e_ymax = hits[0].y;
        foreach (hits[i]) begin
          if (hits[i].x < e_xmin) e_xmin = hits[i].x;
          if (hits[i].x > e_xmax) e_xmax = hits[i].x;
          if (hits[i].y < e_ymin) e_ymin = hits[i].y;
          if (hits[i].y > e_ymax) e_ymax = hits[i].y;
        end
        e_xc = (e_xmin + e_xmax) / 2;
        e_yc = (e_ymin + e_ymax) / 2;
      end else begin
        e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
        e_xc = 0; e_yc = 0;
      end
    end
    hits.delete();
    m_row = 0;
    pulses += int'(obj_valid);
    check_results("close");
    step();
    pulses += int'(obj_valid);
    step();
    pulses += int'(obj_valid);
    chk("obj_valid_pulses", pulses, pub);
    pix_vsync = 1'b0;
    step();
    chk("obj_valid_idle", obj_valid, 1'b0);
    check_results("hold");
  endtask

  initial begin
    mvec[0]  = '{16'hF800, 16'hFFFF};
    mvec[1]  = '{16'h07E0, 16'h0000};
    mvec[2]  = '{16'h001F, 16'h0000};
    mvec[3]  = '{16'hA000, 16'hFFFF};
    mvec[4]  = '{16'h9800, 16'h0000};
    mvec[5]  = '{16'hA300, 16'hFFFF};
    mvec[6]  = '{16'hA320, 16'h0000};
    mvec[7]  = '{16'hA00C, 16'hFFFF};
    mvec[8]  = '{16'hA00D, 16'h0000};
    mvec[9]  = '{16'hFFFF, 16'h0000};
    mvec[10] = '{16'h0000, 16'h0000};

    // Reset state
    rst_n = 1'b0;
    step(); step(); step();
    chk("rst_obj_valid", obj_valid, 1'b0);
    chk("rst_bin_en", bin_en, 1'b0);
    chk("rst_bin_data", bin_data, 16'h0000);
    check_results("rst");
    rst_n = 1'b1;
    step();

    // Mask truth table, before the first frame is armed
    for (int i = 0; i < 11; i++) begin
      pix_en = 1'b1;
      pix_data = mvec[i].d;
      step();
      chk("mask_vec", bin_data, mvec[i].exp);
    end
    pix_en = 1'b0;
    step();

    // First vsync only arms
    close_frame();

    // All-black frame
    clear_img();
    drive_frame(4, 8, 1'b0);
    close_frame();

    // Three red pixels
    clear_img();
    img[1][2] = 16'hF800; img[1][5] = 16'hF800; img[3][3] = 16'hF800;
    drive_frame(4, 8, 1'b0);
    close_frame();
    chk("hand_xc", x_center, 3);
    chk("hand_yc", y_center, 2);
    chk("hand_cnt3", hit_cnt, 3);

    // Single hit below the threshold, then an empty frame
    clear_img();
    img[0][7] = 16'hF800;
    drive_frame(4, 8, 1'b0);
    close_frame();
    chk("hand_single_cnt", hit_cnt, 1);
    chk("hand_single_found", obj_found, 1'b0);
    clear_img();
    drive_frame(4, 8, 1'b0);
    close_frame();
    chk("hand_cleared_cnt", hit_cnt, 0);

    // Over-long line and out-of-window row
    clear_img();
    for (int c = 0; c < 10; c++) begin
      img[0][c] = 16'hF800;
      img[5][c] = 16'hF800;
    end
    drive_frame(6, 10, 1'b0);
    close_frame();
    chk("hand_long_xmax", x_max, 7);
    chk("hand_long_cnt", hit_cnt, 8);

    // Reset mid-frame after five hits
    clear_img();
    for (int c = 0; c < 5; c++) img[0][c] = 16'hF800;
    drive_line(0, 8, 1'b0);
    rst_n = 1'b0;
    step(); step(); step();
    chk("midrst_obj_valid", obj_valid, 1'b0);
    chk("midrst_bin_en", bin_en, 1'b0);
    chk("midrst_bin_data", bin_data, 16'h0000);
    m_armed = 1'b0; hits.delete(); m_row = 0;
    e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
    e_xc = 0; e_yc = 0; e_cnt = 0;
    check_results("midrst");
    rst_n = 1'b1;
    step();
    clear_img();
    img[0][1] = 16'hF800; img[1][6] = 16'hF800;
    drive_frame(2, 8, 1'b0);
    close_frame();
    clear_img();
    img[2][4] = 16'hF800; img[3][6] = 16'hF800;
    drive_frame(4, 8, 1'b0);
    close_frame();
    chk("hand_postrst_cnt", hit_cnt, 2);
    chk("hand_postrst_xmin", x_min, 4);

    // Randomized frames against the model
    for (int f = 0; f < 25; f++) begin
      int rows, cols;
      rows = $urandom_range(2, 6);
      cols = $urandom_range(4, 11);
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 12; c++)
          img[r][c] = ($urandom_range(0, 9) < 3) ? rand_target() : 16'($urandom);
      drive_frame(rows, cols, 1'b1);
      close_frame();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
